// File: rtl/alu_pkg.sv
// Shared decode constants and types for the ALU execute stage.
// The optional iterative multiplier is enabled by defining ALU_MUL_EN.
package alu_pkg;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_LUI,
        ALU_AUIPC,
        ALU_MUL,
        ALU_ILLEGAL
    } alu_op_e;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_e;

    typedef struct packed {
        alu_op_e op;
        logic    word;
        logic    use_imm;
        logic    u_type;
    } dec_t;

endpackage

// File: rtl/alu_exec_dec.sv
// Combinational decoder: opcode/func7/func3 -> ALU operation plus word/immediate flags.
// MUL/MULW decode only when ALU_MUL_EN is defined; otherwise they fall through to illegal.
module alu_exec_dec
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [6:0] i_opcode,
    input  logic [6:0] i_func7,
    input  logic [2:0] i_func3,
    output dec_t       o_dec
);

    logic [6:0] w_f7_shift;
    logic       w_is_word;
    logic       w_word_ok;

    // On RV64 the low funct7 bit of an immediate shift is shamt[5], not an opcode bit.
    assign w_f7_shift = (XLEN == 64) ? {i_func7[6:1], 1'b0} : i_func7;
    assign w_is_word  = (i_opcode == OPC_OP_IMM_32) || (i_opcode == OPC_OP_32);
    assign w_word_ok  = (XLEN == 64);

    always_comb begin
        // NOTE: every field gets a default first so no path leaves one unassigned (no latch).
        o_dec.op      = ALU_ILLEGAL;
        o_dec.word    = 1'b0;
        o_dec.use_imm = 1'b0;
        o_dec.u_type  = 1'b0;
        case (i_opcode)
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                if (i_opcode == OPC_OP_IMM || w_word_ok) begin
                    o_dec.word    = w_is_word;
                    o_dec.use_imm = 1'b1;
                    case (i_func3)
                        3'b000: o_dec.op = ALU_ADD;
                        3'b001: if (w_f7_shift == F7_BASE) o_dec.op = ALU_SLL;
                        3'b101: begin
                            if (w_f7_shift == F7_BASE)     o_dec.op = ALU_SRL;
                            else if (w_f7_shift == F7_ALT) o_dec.op = ALU_SRA;
                        end
                        3'b010: if (!w_is_word) o_dec.op = ALU_SLT;
                        3'b011: if (!w_is_word) o_dec.op = ALU_SLTU;
                        3'b100: if (!w_is_word) o_dec.op = ALU_XOR;
                        3'b110: if (!w_is_word) o_dec.op = ALU_OR;
                        default: if (!w_is_word) o_dec.op = ALU_AND;
                    endcase
                end
            end
            OPC_OP, OPC_OP_32: begin
                if (i_opcode == OPC_OP || w_word_ok) begin
                    o_dec.word = w_is_word;
                    if (i_func7 == F7_BASE) begin
                        case (i_func3)
                            3'b000: o_dec.op = ALU_ADD;
                            3'b001: o_dec.op = ALU_SLL;
                            3'b101: o_dec.op = ALU_SRL;
                            3'b010: if (!w_is_word) o_dec.op = ALU_SLT;
                            3'b011: if (!w_is_word) o_dec.op = ALU_SLTU;
                            3'b100: if (!w_is_word) o_dec.op = ALU_XOR;
                            3'b110: if (!w_is_word) o_dec.op = ALU_OR;
                            default: if (!w_is_word) o_dec.op = ALU_AND;
                        endcase
                    end else if (i_func7 == F7_ALT) begin
                        if (i_func3 == 3'b000)      o_dec.op = ALU_SUB;
                        else if (i_func3 == 3'b101) o_dec.op = ALU_SRA;
                    end
`ifdef ALU_MUL_EN
                    else if (i_func7 == F7_MULDIV && i_func3 == 3'b000) begin
                        o_dec.op = ALU_MUL;
                    end
`endif
                end
            end
            OPC_LUI: begin
                o_dec.op      = ALU_LUI;
                o_dec.use_imm = 1'b1;
                o_dec.u_type  = 1'b1;
            end
            OPC_AUIPC: begin
                o_dec.op      = ALU_AUIPC;
                o_dec.use_imm = 1'b1;
                o_dec.u_type  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered RV32I/RV64I integer execute stage with valid/ready on both sides.
// Define ALU_MUL_EN to build the radix-2 shift-add multiplier (MUL/MULW) and its BUSY state.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [6:0]      opcode,
    input  logic [6:0]      func7,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [19:0]     imm,
    input  logic [XLEN-1:0] pc,
    input  logic [4:0]      i_rd_indx,
    input  logic            i_valid,
    output logic            i_ready,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [4:0]      o_rd_indx,
    output logic [XLEN-1:0] rd,
    output logic            o_illegal
);

    localparam int SHW = (XLEN == 64) ? 6 : 5;

    dec_t            w_dec;
    logic            w_accept;
    logic [XLEN-1:0] w_imm_i, w_imm_u, w_op_b, w_shift_src, w_res;
    logic [SHW-1:0]  w_shamt;
    logic            w_load, w_load_ill;
    logic [XLEN-1:0] w_load_rd;
    logic [4:0]      w_load_indx;

    logic            r_valid, r_illegal;
    logic [XLEN-1:0] r_rd;
    logic [4:0]      r_rd_indx;

    alu_exec_dec #(.XLEN(XLEN)) u_dec (
        .i_opcode (opcode),
        .i_func7  (func7),
        .i_func3  (func3),
        .o_dec    (w_dec)
    );

    assign w_accept = i_valid && i_ready;
    assign w_imm_i  = XLEN'($signed(imm[11:0]));
    assign w_imm_u  = XLEN'($signed({imm, 12'b0}));
    assign w_op_b   = !w_dec.use_imm ? rs2 : (w_dec.u_type ? w_imm_u : w_imm_i);
    assign w_shamt  = w_dec.word ? SHW'(w_op_b[4:0]) : w_op_b[SHW-1:0];

    // Word right shifts must see only the low 32 bits, zero- or sign-extended by shift type.
    always_comb begin
        w_shift_src = rs1;
        if (w_dec.word)
            w_shift_src = (w_dec.op == ALU_SRA) ? XLEN'($signed(rs1[31:0])) : XLEN'(rs1[31:0]);
    end

    always_comb begin
        w_res = '0;
        case (w_dec.op)
            ALU_ADD:   w_res = rs1 + w_op_b;
            ALU_SUB:   w_res = rs1 - w_op_b;
            ALU_SLL:   w_res = w_shift_src << w_shamt;
            ALU_SRL:   w_res = w_shift_src >> w_shamt;
            ALU_SRA:   w_res = XLEN'($signed(w_shift_src) >>> w_shamt);
            ALU_SLT:   w_res = XLEN'($signed(rs1) < $signed(w_op_b));
            ALU_SLTU:  w_res = XLEN'(rs1 < w_op_b);
            ALU_XOR:   w_res = rs1 ^ w_op_b;
            ALU_OR:    w_res = rs1 | w_op_b;
            ALU_AND:   w_res = rs1 & w_op_b;
            ALU_LUI:   w_res = w_imm_u;
            ALU_AUIPC: w_res = pc + w_imm_u;
            default:   w_res = '0;
        endcase
        if (w_dec.word)
            w_res = XLEN'($signed(w_res[31:0]));
    end

`ifdef ALU_MUL_EN
    localparam int CW = $clog2(XLEN + 1);

    state_e          r_state;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_acc, r_mcand, r_mplier;
    logic            r_mul_word;
    logic [4:0]      r_mul_indx;
    logic [XLEN-1:0] w_mul_sum;
    logic            w_mul_done;

    assign w_mul_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_done = (r_state == ST_BUSY) && (r_cnt == CW'(1));
    assign i_ready    = (r_state == ST_IDLE) && (!r_valid || o_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the multiplier datapath is reset as well so a discarded multiply leaves no trace.
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_mul_word <= 1'b0;
            r_mul_indx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_dec.op == ALU_MUL) begin
                        r_state    <= ST_BUSY;
                        r_cnt      <= w_dec.word ? CW'(32) : CW'(XLEN);
                        r_acc      <= '0;
                        r_mcand    <= rs1;
                        r_mplier   <= rs2;
                        r_mul_word <= w_dec.word;
                        r_mul_indx <= i_rd_indx;
                    end
                end
                default: begin
                    r_acc    <= w_mul_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - CW'(1);
                    if (w_mul_done)
                        r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_load      = (w_accept && w_dec.op != ALU_MUL) || w_mul_done;
        w_load_rd   = w_res;
        w_load_indx = i_rd_indx;
        w_load_ill  = (w_dec.op == ALU_ILLEGAL);
        if (w_mul_done) begin
            w_load_rd   = r_mul_word ? XLEN'($signed(w_mul_sum[31:0])) : w_mul_sum;
            w_load_indx = r_mul_indx;
            w_load_ill  = 1'b0;
        end
    end
`else
    assign i_ready = !r_valid || o_ready;

    always_comb begin
        w_load      = w_accept;
        w_load_rd   = w_res;
        w_load_indx = i_rd_indx;
        w_load_ill  = (w_dec.op == ALU_ILLEGAL);
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n) begin
            r_valid   <= 1'b0;
            r_rd      <= '0;
            r_rd_indx <= '0;
            r_illegal <= 1'b0;
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_rd      <= w_load_rd;
            r_rd_indx <= w_load_indx;
            r_illegal <= w_load_ill;
        end else if (r_valid && o_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid   = r_valid;
    assign rd        = r_rd;
    assign o_rd_indx = r_rd_indx;
    assign o_illegal = r_illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage (XLEN=64): vector table plus scoreboard queue,
// with hand-written sequences for stall, multiply latency and reset during a multiply.
module tb_alu_exec_stage;

    localparam int XLEN = 64;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    localparam logic [6:0] T_OP = 7'b0110011, T_OPI = 7'b0010011, T_OP32 = 7'b0111011;
    localparam logic [6:0] T_OPI32 = 7'b0011011, T_LUI = 7'b0110111, T_AUIPC = 7'b0010111;

    typedef struct {
        string       name;
        logic [6:0]  opc;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] b;
        logic [19:0] im;
        logic [63:0] p;
        logic [4:0]  idx;
        logic [63:0] exp_rd;
        logic        exp_ill;
    } vec_t;

    typedef struct {
        string       name;
        logic [63:0] rd;
        logic [4:0]  idx;
        logic        ill;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [6:0]      opcode = '0, func7 = '0;
    logic [2:0]      func3 = '0;
    logic [XLEN-1:0] rs1 = '0, rs2 = '0, pc = '0;
    logic [19:0]     imm = '0;
    logic [4:0]      i_rd_indx = '0;
    logic            i_valid = 1'b0, o_ready = 1'b1;
    logic            i_ready, o_valid, o_illegal;
    logic [4:0]      o_rd_indx;
    logic [XLEN-1:0] rd;

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];
    vec_t vecs[20];
    int   n_vec = 0;

    alu_exec_stage #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .opcode    (opcode),
        .func7     (func7),
        .func3     (func3),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .pc        (pc),
        .i_rd_indx (i_rd_indx),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_rd_indx (o_rd_indx),
        .rd        (rd),
        .o_illegal (o_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [6:0] opc, input logic [6:0] f7,
                                input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                                input logic [19:0] im, input logic [63:0] p, input logic [4:0] idx,
                                input logic [63:0] exp_rd, input logic exp_ill);
        vec_t v;
        v.name = name; v.opc = opc; v.f7 = f7; v.f3 = f3; v.a = a; v.b = b; v.im = im;
        v.p = p; v.idx = idx; v.exp_rd = exp_rd; v.exp_ill = exp_ill;
        return v;
    endfunction

    // Drive one request, hold it until accepted, and log the expected result.
    task automatic send(input vec_t v, input bit do_push, output int waits);
        exp_t e;
        opcode = v.opc; func7 = v.f7; func3 = v.f3; rs1 = v.a; rs2 = v.b;
        imm = v.im; pc = v.p; i_rd_indx = v.idx; i_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!i_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!i_ready) begin
            check({v.name, "_accept_timeout"}, 64'(i_ready), 64'd1);
        end else if (do_push) begin
            e.name = v.name; e.rd = v.exp_rd; e.idx = v.idx; e.ill = v.exp_ill;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Scoreboard: every consumed result is compared against the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && o_valid && o_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'(o_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_rd"}, rd, e.rd);
                check({e.name, "_indx"}, 64'(o_rd_indx), 64'(e.idx));
                check({e.name, "_illegal"}, 64'(o_illegal), 64'(e.ill));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   waits;
        int   busy;
        vec_t v;

        vecs[n_vec++] = mk("addw", T_OP32, 7'h00, 3'b000, 64'h7FFF_FFFF, 64'd1, '0, '0, 5'd4, 64'hFFFF_FFFF_8000_0000, 1'b0);
        vecs[n_vec++] = mk("srai63", T_OPI, 7'b0100001, 3'b101, 64'h8000_0000_0000_0000, '0, 20'h0043F, '0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        vecs[n_vec++] = mk("sub", T_OP, 7'b0100000, 3'b000, 64'd3, 64'd5, '0, '0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        vecs[n_vec++] = mk("slt", T_OP, 7'h00, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, '0, '0, 5'd7, 64'd1, 1'b0);
        vecs[n_vec++] = mk("sltu", T_OP, 7'h00, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, '0, '0, 5'd8, 64'd0, 1'b0);
        vecs[n_vec++] = mk("xor", T_OP, 7'h00, 3'b100, 64'hF0F0, 64'h0FF0, '0, '0, 5'd9, 64'hFF00, 1'b0);
        vecs[n_vec++] = mk("or", T_OP, 7'h00, 3'b110, 64'hF0F0, 64'h0FF0, '0, '0, 5'd10, 64'hFFF0, 1'b0);
        vecs[n_vec++] = mk("and", T_OP, 7'h00, 3'b111, 64'hF0F0, 64'h0FF0, '0, '0, 5'd11, 64'h00F0, 1'b0);
        vecs[n_vec++] = mk("sll63", T_OP, 7'h00, 3'b001, 64'd1, 64'h7F, '0, '0, 5'd12, 64'h8000_0000_0000_0000, 1'b0);
        vecs[n_vec++] = mk("srl", T_OP, 7'h00, 3'b101, 64'h8000_0000_0000_0000, 64'd4, '0, '0, 5'd13, 64'h0800_0000_0000_0000, 1'b0);
        vecs[n_vec++] = mk("lui", T_LUI, 7'h00, 3'b000, '0, '0, 20'h80000, '0, 5'd14, 64'hFFFF_FFFF_8000_0000, 1'b0);
        vecs[n_vec++] = mk("auipc", T_AUIPC, 7'h00, 3'b000, '0, '0, 20'h00001, 64'h1000, 5'd15, 64'h2000, 1'b0);
        vecs[n_vec++] = mk("slliw31", T_OPI32, 7'h00, 3'b001, 64'd1, '0, 20'h0001F, '0, 5'd16, 64'hFFFF_FFFF_8000_0000, 1'b0);
        vecs[n_vec++] = mk("sraw", T_OP32, 7'b0100000, 3'b101, 64'h0000_0000_8000_0000, 64'd4, '0, '0, 5'd17, 64'hFFFF_FFFF_F800_0000, 1'b0);
        vecs[n_vec++] = mk("srliw", T_OPI32, 7'h00, 3'b101, 64'hFFFF_FFFF_8000_0000, '0, 20'h00004, '0, 5'd18, 64'h0800_0000, 1'b0);
        vecs[n_vec++] = mk("slti", T_OPI, 7'h00, 3'b010, 64'hFFFF_FFFF_FFFF_FFFB, '0, 20'h00FFF, '0, 5'd19, 64'd1, 1'b0);
        vecs[n_vec++] = mk("sltiu", T_OPI, 7'h00, 3'b011, 64'd5, '0, 20'h00FFF, '0, 5'd20, 64'd1, 1'b0);
        vecs[n_vec++] = mk("ill_f7", T_OP, 7'b0000010, 3'b000, 64'd9, 64'd9, '0, '0, 5'd21, 64'd0, 1'b1);
        vecs[n_vec++] = mk("after_ill", T_OP, 7'h00, 3'b000, 64'd2, 64'd3, '0, '0, 5'd22, 64'd5, 1'b0);
        vecs[n_vec++] = mk("mulw", T_OP32, 7'b0000001, 3'b000, 64'hFFFF_FFFF, 64'd2, '0, '0, 5'd23,
                           MUL_EN ? 64'hFFFF_FFFF_FFFF_FFFE : 64'd0, !MUL_EN);

        // Reset values.
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_rd", rd, 64'd0);
        check("rst_indx", 64'(o_rd_indx), 64'd0);
        check("rst_illegal", 64'(o_illegal), 64'd0);
        check("rst_i_ready", 64'(i_ready), 64'd1);
        @(posedge clk);
        #1;

        // ADDI with a negative immediate; result must be visible the very next cycle.
        send(mk("addi", T_OPI, 7'h00, 3'b000, 64'd5, '0, 20'h00FFF, '0, 5'd3, 64'd4, 1'b0), 1'b1, waits);
        check("addi_latency", 64'(o_valid), 64'd1);

        // Table: back-to-back, one accept per cycle.
        for (int i = 0; i < n_vec; i++) begin
            send(vecs[i], 1'b1, waits);
            check({vecs[i].name, "_waits"}, 64'(waits), 64'd0);
        end

        // MUL latency: i_ready low for XLEN cycles, then the result is held.
        v = mk("mul", T_OP, 7'b0000001, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, '0, '0, 5'd24,
               MUL_EN ? 64'hFFFF_FFFF_FFFF_FFFD : 64'd0, !MUL_EN);
        send(v, 1'b1, waits);
        busy = 0;
        @(negedge clk);
        while (!i_ready && busy < 200) begin
            busy++;
            @(negedge clk);
        end
        check("mul_busy_cycles", 64'(busy), MUL_EN ? 64'd64 : 64'd0);
        check("mul_o_valid", 64'(o_valid), 64'd1);
        @(posedge clk);
        #1;

        // Stall: result held with o_ready low, next op waits, then flows without loss.
        send(mk("stall_add", T_OP, 7'h00, 3'b000, 64'd10, 64'd20, '0, '0, 5'd9, 64'd30, 1'b0), 1'b1, waits);
        o_ready = 1'b0;
        opcode = T_OP; func7 = 7'h00; func3 = 3'b000; rs1 = 64'd1; rs2 = 64'd1; i_rd_indx = 5'd25;
        i_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_rd", rd, 64'd30);
            check("stall_o_valid", 64'(o_valid), 64'd1);
            check("stall_i_ready", 64'(i_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        o_ready = 1'b1;
        send(mk("post_stall", T_OP, 7'h00, 3'b000, 64'd1, 64'd1, '0, '0, 5'd25, 64'd2, 1'b0), 1'b1, waits);
        check("post_stall_waits", 64'(waits), 64'd0);
        repeat (2) @(negedge clk);
        check("stall_drained", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;

        // Reset during a multiply: nothing may come out afterwards.
        send(v, !MUL_EN, waits);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_o_valid", 64'(o_valid), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_i_ready", 64'(i_ready), 64'd1);
        check("midrst_o_valid_after", 64'(o_valid), 64'd0);
        repeat (80) @(negedge clk);
        check("midrst_no_stale", 64'(o_valid), 64'd0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
